// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : calc_pkg
// Brief    : Shared op codes and sequencer state encoding for the calculator
//            front end and the arithmetic-unit decode.
// Revision : 1.0 - initial release
// ============================================================================
package calc_pkg;

    // Op codes: the bit index of the one-hot operator key equals the code
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_LSL = 3'd4;
    localparam logic [2:0] OP_LSR = 3'd5;
    localparam logic [2:0] OP_ASL = 3'd6;
    localparam logic [2:0] OP_ASR = 3'd7;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // waiting for an operator
        ST_OPB  = 2'd1,   // operator held, waiting for equals
        ST_REQ  = 2'd2,   // request outstanding to the arithmetic unit
        ST_ERR  = 2'd3    // divide-by-zero, waiting for clear
    } state_t;

endpackage : calc_pkg
`default_nettype wire

// File: rtl/op_key_encoder.sv
`default_nettype none
// ============================================================================
// Module   : op_key_encoder
// Brief    : One-hot operator key to 3-bit op code; the lowest set bit wins
//            when several keys are pressed together. valid = any key.
// Revision : 1.0 - initial release
// ============================================================================
module op_key_encoder
    import calc_pkg::*;
(
    input  logic [7:0] key,
    output logic [2:0] code,
    output logic       valid
);

    // Scan from the top down so the lowest set index is the last to write
    always_comb begin
        code  = OP_ADD;
        valid = |key;
        for (int i = 7; i >= 0; i--) begin
            if (key[i]) begin
                code = 3'(i);
            end
        end
    end

endmodule : op_key_encoder
`default_nettype wire

// File: rtl/calc_op_issuer.sv
`default_nettype none
// ============================================================================
// Module   : calc_op_issuer
// Brief    : Turns operator / equals / clear key events into one req/ack
//            transaction on the arithmetic unit and returns its result.
//            Optional feature macro: CALC_OP_CHAIN_EN (running computation:
//            the previous result becomes operand A when no digits were typed).
// Revision : 1.0 - initial release
// ============================================================================
module calc_op_issuer
    import calc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] entry_val,
    input  logic             entry_dirty,
    input  logic [7:0]       op_key,
    input  logic             eq_key,
    input  logic             clr_key,
    output logic             entry_clr,
    output logic             au_req,
    output logic [2:0]       au_op,
    output logic [WIDTH-1:0] au_a,
    output logic [WIDTH-1:0] au_b,
    input  logic             au_ack,
    input  logic [WIDTH-1:0] au_result,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             busy,
    output logic             err
);

    logic [2:0]       w_key_code;
    logic             w_key_valid;
    logic [WIDTH-1:0] w_op_a;

    state_t           r_state,        w_state_nxt;
    logic [WIDTH-1:0] r_a,            w_a_nxt;
    logic [WIDTH-1:0] r_b,            w_b_nxt;
    logic [WIDTH-1:0] r_result,       w_result_nxt;
    logic [2:0]       r_op,           w_op_nxt;
    logic             r_au_req,       w_au_req_nxt;
    logic             r_result_valid, w_result_valid_nxt;
    logic             r_entry_clr,    w_entry_clr_nxt;
    logic             r_err,          w_err_nxt;
    logic             r_clr_pend,     w_clr_pend_nxt;

    op_key_encoder u_op_key_encoder (
        .key   (op_key),
        .code  (w_key_code),
        .valid (w_key_valid)
    );

`ifdef CALC_OP_CHAIN_EN
    logic r_chain, w_chain_nxt;

    // Chain flag: set by a delivered result, dropped by the next accepted
    // operator or by any clear
    always_comb begin
        w_chain_nxt = r_chain;
        if (clr_key) begin
            w_chain_nxt = 1'b0;
        end else if (r_state == ST_IDLE && w_key_valid) begin
            w_chain_nxt = 1'b0;
        end else if (r_state == ST_REQ && au_ack && !r_clr_pend) begin
            w_chain_nxt = 1'b1;
        end
    end

    // Chain flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= 1'b0;
        end else begin
            r_chain <= w_chain_nxt;
        end
    end

    assign w_op_a = (r_chain && !entry_dirty) ? r_result : entry_val;
`else
    logic w_unused_dirty;
    assign w_unused_dirty = entry_dirty;
    assign w_op_a         = entry_val;
`endif

    // Next-state and next-output decode; clear beats equals beats operator
    always_comb begin
        w_state_nxt        = r_state;
        w_a_nxt            = r_a;
        w_b_nxt            = r_b;
        w_op_nxt           = r_op;
        w_result_nxt       = r_result;
        w_au_req_nxt       = r_au_req;
        w_err_nxt          = r_err;
        w_clr_pend_nxt     = r_clr_pend;
        w_result_valid_nxt = 1'b0;
        w_entry_clr_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (clr_key) begin
                    w_err_nxt       = 1'b0;
                    w_entry_clr_nxt = 1'b1;
                end else if (w_key_valid) begin
                    w_a_nxt         = w_op_a;
                    w_op_nxt        = w_key_code;
                    w_entry_clr_nxt = 1'b1;
                    w_state_nxt     = ST_OPB;
                end
            end
            ST_OPB: begin
                if (clr_key) begin
                    w_entry_clr_nxt = 1'b1;
                    w_state_nxt     = ST_IDLE;
                end else if (eq_key) begin
                    w_b_nxt = entry_val;
                    if (r_op == OP_DIV && entry_val == '0) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_ERR;
                    end else begin
                        w_au_req_nxt = 1'b1;
                        w_state_nxt  = ST_REQ;
                    end
                end else if (w_key_valid) begin
                    w_op_nxt = w_key_code;
                end
            end
            ST_REQ: begin
                // The handshake always completes; a clear only discards it
                if (au_ack) begin
                    w_au_req_nxt   = 1'b0;
                    w_clr_pend_nxt = 1'b0;
                    w_state_nxt    = ST_IDLE;
                    if (r_clr_pend || clr_key) begin
                        w_entry_clr_nxt = 1'b1;
                    end else begin
                        w_result_nxt       = au_result;
                        w_result_valid_nxt = 1'b1;
                    end
                end else if (clr_key) begin
                    w_clr_pend_nxt = 1'b1;
                end
            end
            ST_ERR: begin
                if (clr_key) begin
                    w_err_nxt       = 1'b0;
                    w_entry_clr_nxt = 1'b1;
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_a            <= '0;
            r_b            <= '0;
            r_op           <= OP_ADD;
            r_result       <= '0;
            r_au_req       <= 1'b0;
            r_err          <= 1'b0;
            r_clr_pend     <= 1'b0;
            r_result_valid <= 1'b0;
            r_entry_clr    <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_a            <= w_a_nxt;
            r_b            <= w_b_nxt;
            r_op           <= w_op_nxt;
            r_result       <= w_result_nxt;
            r_au_req       <= w_au_req_nxt;
            r_err          <= w_err_nxt;
            r_clr_pend     <= w_clr_pend_nxt;
            r_result_valid <= w_result_valid_nxt;
            r_entry_clr    <= w_entry_clr_nxt;
        end
    end

    assign entry_clr    = r_entry_clr;
    assign au_req       = r_au_req;
    assign au_op        = r_op;
    assign au_a         = r_a;
    assign au_b         = r_b;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign busy         = r_au_req;
    assign err          = r_err;

endmodule : calc_op_issuer
`default_nettype wire

// File: tb/tb_calc_op_issuer.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_op_issuer
// Brief    : Self-checking bench for calc_op_issuer: vector table, hand-written
//            corner sequences and randomized calculations against a
//            transaction-level model. Chain checks need CALC_OP_CHAIN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_op_issuer;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] entry_val;
    logic             entry_dirty;
    logic [7:0]       op_key;
    logic             eq_key;
    logic             clr_key;
    logic             entry_clr;
    logic             au_req;
    logic [2:0]       au_op;
    logic [WIDTH-1:0] au_a;
    logic [WIDTH-1:0] au_b;
    logic             au_ack;
    logic [WIDTH-1:0] au_result;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             busy;
    logic             err;

    int n_cmp = 0;
    int n_err = 0;

    calc_op_issuer #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .entry_val    (entry_val),
        .entry_dirty  (entry_dirty),
        .op_key       (op_key),
        .eq_key       (eq_key),
        .clr_key      (clr_key),
        .entry_clr    (entry_clr),
        .au_req       (au_req),
        .au_op        (au_op),
        .au_a         (au_a),
        .au_b         (au_b),
        .au_ack       (au_ack),
        .au_result    (au_result),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  k1;
        logic [7:0]  k2;     // optional replacement operator in OPB (0 = none)
        logic [15:0] b;
        int          dly;    // idle request cycles before ack
        logic [2:0]  exp_op;
        logic        exp_err;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Arithmetic unit behaviour used to produce responses
    function automatic logic [15:0] au_model(input logic [2:0] op, input logic [15:0] a,
                                             input logic [15:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a * b;
            3'd3:    return a / b;
            3'd4:    return a << b[3:0];
            3'd5:    return a >> b[3:0];
            3'd6:    return a << b[3:0];
            default: return 16'($signed(a) >>> b[3:0]);
        endcase
    endfunction

    function automatic logic [2:0] lowest_idx(input logic [7:0] k);
        for (int i = 0; i < 8; i++) begin
            if (k[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    // One full calculation: operator, optional replacement, equals, handshake
    task automatic do_calc(input string nm, input logic [15:0] a, input logic [7:0] k1,
                           input logic [7:0] k2, input logic [15:0] b, input int dly,
                           input logic [2:0] exp_op, input logic exp_err);
        logic [15:0] res;
        entry_val = a;
        op_key    = k1;
        step();
        op_key = 8'h00;
        chk({nm, " entry_clr on op"}, 32'(entry_clr), 32'd1);
        chk({nm, " au_a captured"}, 32'(au_a), 32'(a));
        if (k2 != 8'h00) begin
            entry_val = a ^ 16'h5A5A;
            op_key    = k2;
            step();
            op_key = 8'h00;
            chk({nm, " no entry_clr on replace"}, 32'(entry_clr), 32'd0);
            chk({nm, " A kept on replace"}, 32'(au_a), 32'(a));
        end
        entry_val = b;
        eq_key    = 1'b1;
        step();
        eq_key = 1'b0;
        chk({nm, " err"}, 32'(err), 32'(exp_err));
        if (exp_err) begin
            chk({nm, " au_req in err"}, 32'(au_req), 32'd0);
            clr_key = 1'b1;
            step();
            clr_key = 1'b0;
            chk({nm, " err cleared"}, 32'(err), 32'd0);
            chk({nm, " entry_clr on clr"}, 32'(entry_clr), 32'd1);
        end else begin
            chk({nm, " au_req"}, 32'(au_req), 32'd1);
            chk({nm, " au_op"}, 32'(au_op), 32'(exp_op));
            chk({nm, " au_a"}, 32'(au_a), 32'(a));
            chk({nm, " au_b"}, 32'(au_b), 32'(b));
            res = au_model(exp_op, a, b);
            repeat (dly) step();
            chk({nm, " au_req held"}, 32'(au_req), 32'd1);
            au_result = res;
            au_ack    = 1'b1;
            step();
            au_ack = 1'b0;
            chk({nm, " result_valid"}, 32'(result_valid), 32'd1);
            chk({nm, " result"}, 32'(result), 32'(res));
            chk({nm, " au_req dropped"}, 32'(au_req), 32'd0);
            chk({nm, " busy dropped"}, 32'(busy), 32'd0);
            step();
            chk({nm, " result_valid pulse"}, 32'(result_valid), 32'd0);
        end
    endtask

    // Enter REQ with a simple ADD
    task automatic enter_req(input logic [15:0] a, input logic [15:0] b);
        entry_val = a;
        op_key    = 8'h01;
        step();
        op_key    = 8'h00;
        entry_val = b;
        eq_key    = 1'b1;
        step();
        eq_key = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb, prev_result;
        logic [7:0]  rk1, rk2;
        logic [2:0]  rop;

        rst_n       = 1'b0;
        entry_val   = '0;
        entry_dirty = 1'b1;
        op_key      = 8'h00;
        eq_key      = 1'b0;
        clr_key     = 1'b0;
        au_ack      = 1'b0;
        au_result   = '0;

        tbl[0] = '{16'd12,    8'h01, 8'h00, 16'd30,    3, 3'd0, 1'b0};
        tbl[1] = '{16'h8000,  8'h80, 8'h00, 16'd3,     0, 3'd7, 1'b0};
        tbl[2] = '{16'd7,     8'h24, 8'h02, 16'd5,     1, 3'd1, 1'b0};
        tbl[3] = '{16'd50,    8'h08, 8'h00, 16'd0,     0, 3'd3, 1'b1};
        tbl[4] = '{16'd50,    8'h18, 8'h00, 16'd0,     0, 3'd3, 1'b1};
        tbl[5] = '{16'd9,     8'hF0, 8'h08, 16'd0,     0, 3'd3, 1'b1};
        tbl[6] = '{16'd1,     8'h40, 8'h00, 16'd0,     2, 3'd6, 1'b0};
        tbl[7] = '{16'd100,   8'h08, 8'h00, 16'd7,     1, 3'd3, 1'b0};
        tbl[8] = '{16'hFFFF,  8'hFF, 8'h00, 16'd1,     0, 3'd0, 1'b0};
        tbl[9] = '{16'd3,     8'h10, 8'h20, 16'hFFFF,  4, 3'd5, 1'b0};

        // Reset state
        #2;
        chk("reset au_req", 32'(au_req), 32'd0);
        chk("reset au_op", 32'(au_op), 32'd0);
        chk("reset au_a", 32'(au_a), 32'd0);
        chk("reset au_b", 32'(au_b), 32'd0);
        chk("reset result", 32'(result), 32'd0);
        chk("reset result_valid", 32'(result_valid), 32'd0);
        chk("reset entry_clr", 32'(entry_clr), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // Equals in IDLE is ignored; ack without a request is ignored
        eq_key    = 1'b1;
        au_ack    = 1'b1;
        au_result = 16'd999;
        step();
        eq_key = 1'b0;
        au_ack = 1'b0;
        chk("idle eq au_req", 32'(au_req), 32'd0);
        chk("stray ack result_valid", 32'(result_valid), 32'd0);
        chk("stray ack result", 32'(result), 32'd0);

        // Vector table
        for (int i = 0; i < 10; i++) begin
            do_calc($sformatf("vec%0d", i), tbl[i].a, tbl[i].k1, tbl[i].k2, tbl[i].b,
                    tbl[i].dly, tbl[i].exp_op, tbl[i].exp_err);
        end

        // Keys ignored in ERR
        entry_val = 16'd4;
        op_key    = 8'h08;
        step();
        op_key    = 8'h00;
        entry_val = 16'd0;
        eq_key    = 1'b1;
        step();
        chk("err set", 32'(err), 32'd1);
        op_key = 8'h01;
        step();
        eq_key = 1'b0;
        op_key = 8'h00;
        chk("err keys ignored au_req", 32'(au_req), 32'd0);
        chk("err keys ignored entry_clr", 32'(entry_clr), 32'd0);
        chk("err sticky", 32'(err), 32'd1);
        clr_key = 1'b1;
        step();
        clr_key = 1'b0;
        chk("err clr", 32'(err), 32'd0);

        // Priority: clr over eq and op in OPB
        entry_val = 16'd4;
        op_key    = 8'h01;
        step();
        clr_key = 1'b1;
        eq_key  = 1'b1;
        op_key  = 8'h02;
        step();
        clr_key = 1'b0;
        op_key  = 8'h00;
        chk("prio clr entry_clr", 32'(entry_clr), 32'd1);
        chk("prio clr au_req", 32'(au_req), 32'd0);
        step();
        eq_key = 1'b0;
        chk("prio clr back to idle", 32'(au_req), 32'd0);

        // Priority: eq over op in OPB; new op accepted with result_valid
        entry_val = 16'd4;
        op_key    = 8'h01;
        step();
        entry_val = 16'd6;
        eq_key    = 1'b1;
        op_key    = 8'h02;
        step();
        eq_key = 1'b0;
        op_key = 8'h00;
        chk("prio eq au_op", 32'(au_op), 32'd0);
        chk("prio eq au_b", 32'(au_b), 32'd6);
        au_ack    = 1'b1;
        au_result = 16'd10;
        step();
        au_ack    = 1'b0;
        chk("prio eq result_valid", 32'(result_valid), 32'd1);
        entry_val = 16'd77;
        op_key    = 8'h04;
        step();
        op_key = 8'h00;
        chk("op in rv cycle entry_clr", 32'(entry_clr), 32'd1);
        chk("op in rv cycle au_op", 32'(au_op), 32'd2);
        chk("op in rv cycle au_a", 32'(au_a), 32'd77);
        clr_key = 1'b1;
        step();
        clr_key = 1'b0;

        // Clear during REQ: handshake completes, result discarded
        prev_result = result;
        enter_req(16'd5, 16'd6);
        clr_key = 1'b1;
        op_key  = 8'h80;
        step();
        clr_key = 1'b0;
        op_key  = 8'h00;
        chk("clr in req au_req", 32'(au_req), 32'd1);
        chk("op in req ignored", 32'(au_op), 32'd0);
        repeat (4) step();
        chk("clr in req held", 32'(au_req), 32'd1);
        au_ack    = 1'b1;
        au_result = 16'd123;
        step();
        au_ack = 1'b0;
        chk("clr in req ack au_req", 32'(au_req), 32'd0);
        chk("clr in req no result_valid", 32'(result_valid), 32'd0);
        chk("clr in req result kept", 32'(result), 32'(prev_result));
        chk("clr in req entry_clr", 32'(entry_clr), 32'd1);
        entry_val = 16'd8;
        op_key    = 8'h01;
        step();
        op_key = 8'h00;
        chk("after clr req idle", 32'(entry_clr), 32'd1);
        clr_key = 1'b1;
        step();
        clr_key = 1'b0;

        // Randomized calculations against the transaction model
        for (int n = 0; n < 40; n++) begin
            ra  = 16'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
            rk1 = 8'($urandom_range(1, 255));
            rk2 = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
            rop = (rk2 != 8'h00) ? lowest_idx(rk2) : lowest_idx(rk1);
            do_calc($sformatf("rnd%0d", n), ra, rk1, rk2, rb, int'($urandom_range(0, 4)),
                    rop, (rop == 3'd3) && (rb == 16'd0));
        end

`ifdef CALC_OP_CHAIN_EN
        // Running computation from the previous result
        do_calc("chain seed", 16'd20, 8'h01, 8'h00, 16'd22, 0, 3'd0, 1'b0);
        entry_dirty = 1'b0;
        entry_val   = 16'd2;
        op_key      = 8'h80;
        step();
        op_key = 8'h00;
        chk("chain au_a", 32'(au_a), 32'd42);
        chk("chain au_op", 32'(au_op), 32'd7);
        eq_key = 1'b1;
        step();
        eq_key = 1'b0;
        chk("chain eq au_a", 32'(au_a), 32'd42);
        chk("chain eq au_b", 32'(au_b), 32'd2);
        au_ack    = 1'b1;
        au_result = 16'd10;
        step();
        au_ack  = 1'b0;
        clr_key = 1'b1;
        step();
        clr_key   = 1'b0;
        entry_val = 16'd5;
        op_key    = 8'h01;
        step();
        op_key = 8'h00;
        chk("chain cleared by clr", 32'(au_a), 32'd5);
        clr_key = 1'b1;
        step();
        clr_key     = 1'b0;
        entry_dirty = 1'b1;
`endif

        // Reset in the middle of a request
        enter_req(16'd11, 16'd22);
        chk("pre-reset au_req", 32'(au_req), 32'd1);
        rst_n = 1'b0;
        #2;
        chk("mid reset au_req", 32'(au_req), 32'd0);
        chk("mid reset busy", 32'(busy), 32'd0);
        chk("mid reset au_a", 32'(au_a), 32'd0);
        chk("mid reset au_b", 32'(au_b), 32'd0);
        chk("mid reset result", 32'(result), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        au_ack    = 1'b1;
        au_result = 16'd55;
        step();
        au_ack = 1'b0;
        chk("post reset no result_valid", 32'(result_valid), 32'd0);
        chk("post reset au_req", 32'(au_req), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_calc_op_issuer
`default_nettype wire

// File: doc/calc_op_issuer.md
# calc_op_issuer

Front-end sequencer that turns operator and equals key events into arithmetic-unit transactions. Captures operand A and the operator, then operand B on equals, and encodes the operator into the 3-bit op code. Issues one request to the arithmetic unit over a req/ack handshake and returns the registered result to the display path. Sits between keypad/number-entry logic and the arithmetic unit, which decodes the op code into its add/sub, shift-direction and logical/arithmetic controls.

## Interface
- WIDTH, 16, operand/result width in bits
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- entry_val  in  WIDTH  current number-entry value
- entry_dirty  in  1  entry holds digits typed since last entry_clr
- op_key  in  8  one-hot operator key pulse; bit index = op code (0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 LSL, 5 LSR, 6 ASL, 7 ASR)
- eq_key  in  1  equals key pulse
- clr_key  in  1  clear key pulse
- entry_clr  out  1  one-cycle pulse: number entry must clear
- au_req  out  1  request to arithmetic unit
- au_op  out  3  op code
- au_a, au_b  out  WIDTH  operands
- au_ack  in  1  arithmetic unit accepts request; au_result valid this cycle
- au_result  in  WIDTH  result from arithmetic unit
- result  out  WIDTH  last completed result
- result_valid  out  1  one-cycle pulse with new result
- busy  out  1  request outstanding
- err  out  1  sticky error, cleared only by clr_key or reset

## Operation
- States: IDLE, OPB (operator held, waiting equals), REQ (request outstanding), ERR.
- IDLE: op_key != 0 -> A <= entry_val, op <= encoded key, entry_clr pulse, -> OPB. eq_key ignored.
- OPB: op_key != 0 -> replace op only (A kept), no entry_clr. eq_key -> B <= entry_val; if op == DIV and B == 0 -> ERR, err <= 1; else -> REQ.
- REQ: au_req = 1; au_op/au_a/au_b held stable until ack; op_key/eq_key ignored. au_ack -> result <= au_result, result_valid pulse, -> IDLE.
- ERR: all keys except clr_key ignored.
- Encoding: multiple op_key bits set -> lowest index wins.
- Priority: clr_key > eq_key > op_key. clr_key in IDLE/OPB/ERR -> IDLE, err <= 0, entry_clr pulse.
- clr_key in REQ: recorded; au_req held until au_ack (handshake never abandoned); at ack result discarded, no result_valid, -> IDLE, entry_clr pulse.
- au_ack while au_req = 0 ignored. au_b passed unmodified for shifts; arithmetic unit uses low bits.

## Timing
- Reset: state IDLE; au_req, au_op, au_a, au_b, result, result_valid, entry_clr, busy, err all 0; chain flag 0.
- All outputs registered.
- eq_key at cycle N -> au_req = 1 from N+1.
- au_ack at cycle M -> au_req = 0, result/result_valid updated at M+1; busy = 0 at M+1.
- Minimum eq_key-to-result_valid: 2 cycles (ack in first req cycle).
- Divide-by-zero: err = 1 at N+1, au_req never asserted.
- New op_key accepted in the cycle result_valid is high.

## Configuration
- CALC_OP_CHAIN_EN defined: after a completed result, next op_key in IDLE with entry_dirty = 0 takes A <= result (running computation); flag cleared by that op_key, clr_key, or reset.
- Undefined: A always <= entry_val; entry_dirty unused.

## Structure
- Package calc_pkg: localparams OP_ADD..OP_ASR (3'd0..3'd7), state enum, shared with arithmetic-unit decode.
- Sub-module op_key_encoder: combinational 8-bit one-hot to 3-bit lowest-index priority encoder plus any-key valid.

## Test plan
- Reset mid-REQ -> all outputs 0, state IDLE, no result_valid.
- entry 12, op_key bit0, entry 30, eq, ack after 3 cycles with 42 -> au_op 0, au_a 12, au_b 30, result 42 with one result_valid pulse.
- op_key 8'b0010_0100 -> au_op 2 (MUL); then op_key bit1 in OPB -> au_op 1, A unchanged, no second entry_clr.
- DIV with B = 0 -> err = 1 next cycle, au_req stays 0; eq/op ignored; clr_key -> err 0, IDLE.
- clr_key during REQ, ack 5 cycles later -> au_req held until ack, no result_valid, IDLE after ack.
- CALC_OP_CHAIN_EN: result 42, op_key ASR with entry_dirty 0, entry 2, eq -> au_a 42, au_op 7, au_b 2.
